// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: bus width, response record and
// the grant-stall LFSR helpers.
package data_mem_responder_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
  } dmem_resp_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
  endfunction

endpackage

// File: rtl/data_mem_resp_pipe.sv
// Fixed-latency response shift register; the last stage drives the bus
// response.
module data_mem_resp_pipe
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  dmem_resp_t i_resp,
  output dmem_resp_t o_resp
);

  dmem_resp_t r_stage [LATENCY];

  // NOTE: pipeline state is small and carries valids, so it is cleared on reset
  // and updated with non-blocking assignments so every stage shifts together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_resp;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_resp = r_stage[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering the core's req/gnt/rvalid data port.
// Optional grant stalling via an LFSR when DATA_MEM_STALL_EN is defined.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = data_mem_responder_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]      r_outstanding;

  logic [IDX_W-1:0] w_idx;
  logic             w_stall;
  logic             w_room;
  logic             w_gnt;
  dmem_resp_t       w_resp_in;
  dmem_resp_t       w_resp_out;

  // Byte-offset and wrap-around address bits are deliberately dropped.
  assign w_idx = data_addr_i[IDX_W+1:2];

  generate
    if (IDX_W + 2 < DATA_WIDTH) begin : g_addr_hi
      logic w_unused_addr;
      assign w_unused_addr = ^{data_addr_i[1:0], data_addr_i[DATA_WIDTH-1:IDX_W+2]};
    end else begin : g_addr_lo
      logic w_unused_addr;
      assign w_unused_addr = ^data_addr_i[1:0];
    end
  endgenerate

`ifdef DATA_MEM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A response leaving this cycle frees its slot for a same-cycle grant.
  always_comb begin
    w_room = (r_outstanding < MAX_CNT) || data_rvalid_o;
    w_gnt  = data_req_i && !rst_i && w_room && !w_stall;
  end

  assign data_gnt_o = w_gnt;

  // NOTE: the storage array has no reset; clearing it would forbid RAM
  // inference, and only the control state needs a known value.
  always_ff @(posedge clk_i) begin
    if (w_gnt && data_we_i) r_mem[w_idx] <= data_wdata_i;
  end

  // NOTE: every field gets a default first so this block cannot infer a latch.
  always_comb begin
    w_resp_in       = '0;
    w_resp_in.valid = w_gnt;
    if (w_gnt && !data_we_i) w_resp_in.rdata = r_mem[w_idx];
  end

  data_mem_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_resp(w_resp_in),
    .o_resp(w_resp_out)
  );

  assign data_rvalid_o = w_resp_out.valid;
  assign data_rdata_o  = w_resp_out.rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_gnt, data_rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  a_outstanding_bounded : assert property (
    @(posedge clk_i) disable iff (rst_i) r_outstanding <= MAX_CNT);

  a_rvalid_has_owner : assert property (
    @(posedge clk_i) disable iff (rst_i) data_rvalid_o |-> (r_outstanding != '0));

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: default instance plus a
// LATENCY=3 / MAX_OUTSTANDING=1 instance for the throughput-limit case.
module tb_data_mem_responder;

  localparam int L0 = 2;
  localparam int L3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req3, we3, gnt3, rvalid3;
  logic [31:0] addr3, wdata3, rdata3;

  data_mem_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_req_i   (req0),
    .data_gnt_o   (gnt0),
    .data_addr_i  (addr0),
    .data_we_i    (we0),
    .data_wdata_i (wdata0),
    .data_rvalid_o(rvalid0),
    .data_rdata_o (rdata0)
  );

  data_mem_responder #(
    .LATENCY        (L3),
    .MAX_OUTSTANDING(1)
  ) dut3 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_req_i   (req3),
    .data_gnt_o   (gnt3),
    .data_addr_i  (addr3),
    .data_we_i    (we3),
    .data_wdata_i (wdata3),
    .data_rvalid_o(rvalid3),
    .data_rdata_o (rdata3)
  );

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int max3     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Starts at a negedge, holds the request until granted, returns at a negedge.
  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       output int waits, output int gcyc);
    bit granted;
    granted = 1'b0;
    waits   = 0;
    gcyc    = -1;
    if (sel == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else          begin req3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wdata; end
    while (!granted && waits < 50) begin
      #1;
      if ((sel == 0) ? gnt0 : gnt3) begin
        granted = 1'b1;
        gcyc    = cyc;
        if (sel == 0) q0.push_back('{exp_rdata, cyc + L0});
        else          q3.push_back('{exp_rdata, cyc + L3});
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    if (sel == 0) req0 = 1'b0;
    else          req3 = 1'b0;
    if (!granted) begin
      n_checks++;
      $display("FAIL grant_timeout: dut%0d addr 0x%08h not granted after %0d cycles", sel, addr, waits);
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q0.size() : q3.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_dut%0d", sel), (sel == 0) ? q0.size() : q3.size(), 0);
    @(negedge clk);
  endtask

  // Monitors: pop one expected response whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rvalid0) begin
      if (q0.size() == 0) begin
        check("rvalid0_unexpected", rvalid0, 1'b0);
      end else begin
        e = q0.pop_front();
        check("rdata0", rdata0, e.rdata);
        check("latency0", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rvalid3) begin
      if (q3.size() == 0) begin
        check("rvalid3_unexpected", rvalid3, 1'b0);
      end else begin
        e = q3.pop_front();
        check("rdata3", rdata3, e.rdata);
        check("latency3", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && int'(dut3.r_outstanding) > max3) max3 <= int'(dut3.r_outstanding);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, g, prev;
    rst  = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
    repeat (2) @(negedge clk);

    // Reset state: grant suppressed even with a request present.
    req0 = 1'b1; req3 = 1'b1;
    #1;
    check("gnt0_in_reset", gnt0, 1'b0);
    check("gnt3_in_reset", gnt3, 1'b0);
    check("rvalid0_in_reset", rvalid0, 1'b0);
    check("rdata0_in_reset", rdata0, 32'h0);
    check("outstanding_in_reset", dut.r_outstanding, 0);
    req0 = 1'b0; req3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write then read back, both granted immediately.
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, w, g);
    check("wr_gnt_wait", w, 0);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, w, g);
    check("rd_gnt_wait", w, 0);
    // Misaligned offset and 4 KiB wrap hit the same word.
    issue(0, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, w, g);
    issue(0, 1'b0, 32'h0000_1010, 32'h0, 32'hDEAD_BEEF, w, g);
    drain(0);

    for (int i = 0; i < 4; i++) issue(0, 1'b1, 32'(i * 4), 32'(i + 1), 32'h0, w, g);
    drain(0);

    // Back-to-back reads: consecutive grants, consecutive responses.
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'(i * 4), 32'h0, 32'(i + 1), w, g);
      check($sformatf("burst_gnt_wait_%0d", i), w, 0);
    end
    drain(0);
    check("outstanding_idle", dut.r_outstanding, 0);

    // Reset one cycle after a granted read: response discarded, memory kept.
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, w, g);
    rst = 1'b1;
    q0.delete();
    #1;
    check("outstanding_after_rst", dut.r_outstanding, 0);
    check("rvalid_during_rst", rvalid0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("no_rvalid_after_rst", rvalid0, 1'b0);
    end
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, w, g);
    check("post_rst_gnt_wait", w, 0);
    drain(0);

    // LATENCY=3, MAX_OUTSTANDING=1: held request granted once every 3 cycles.
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      issue(3, 1'b1, 32'(i * 4), 32'(32'h100 + i), 32'h0, w, g);
      if (i == 0) check("dut3_first_wait", w, 0);
      else        check($sformatf("dut3_wr_spacing_%0d", i), g - prev, 3);
      prev = g;
    end
    for (int i = 0; i < 5; i++) begin
      issue(3, 1'b0, 32'(i * 4), 32'h0, 32'(32'h100 + i), w, g);
      check($sformatf("dut3_rd_spacing_%0d", i), g - prev, 3);
      prev = g;
    end
    drain(3);
    check("dut3_max_outstanding", max3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
